// File: rtl/vga_frame_reader_if.sv
// Bundle between the VGA frame reader, the frame buffer's display read port
// and the VGA connector.
interface vga_frame_reader_if;
  logic [15:0] fb_addr;
  logic        fb_re;
  logic [11:0] fb_rdata;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        in_vblank;
  logic        frame_start;

  // Reader side: issues reads, drives the monitor.
  modport master (
    output fb_addr, fb_re, vga_r, vga_g, vga_b, vga_hs, vga_vs, in_vblank, frame_start,
    input  fb_rdata
  );

  // Frame buffer / monitor side.
  modport slave (
    input  fb_addr, fb_re, vga_r, vga_g, vga_b, vga_hs, vga_vs, in_vblank, frame_start,
    output fb_rdata
  );
endinterface

// File: rtl/vga_frame_reader.sv
// VGA frame reader: generates 640x480@60 timing and shows the 256x192 frame
// buffer as a centred, pixel-doubled window. Border and blanking are black.
// Two-stage per-pixel pipeline: stage A (div_cnt==0) issues the buffer read,
// stage B (div_cnt==1) captures the returned colour together with sync/blank
// so all monitor outputs stay aligned.
module vga_frame_reader #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int WIN_X0  = 64,
  parameter int WIN_Y0  = 48,
  parameter int SRC_W   = 256,
  parameter int SRC_H   = 192
) (
  input  logic              clk,
  input  logic              rst,
  vga_frame_reader_if.master bus
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_B    = DIV_W'(1);
  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] WX0    = 10'(WIN_X0);
  localparam logic [9:0] WX1    = 10'(WIN_X0 + 2 * SRC_W);
  localparam logic [9:0] WY0    = 10'(WIN_Y0);
  localparam logic [9:0] WY1    = 10'(WIN_Y0 + 2 * SRC_H);
  localparam logic [9:0] HS0    = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS1    = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS0    = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS1    = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] VVIS   = 10'(V_VIS);

  // Window offsets halved give the source column/row ({row, col} address).
  function automatic logic [15:0] pack_addr(input logic [9:0] h_off, input logic [9:0] v_off);
    return {8'(v_off >> 1), 8'(h_off >> 1)};
  endfunction

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic             frame_start_q, frame_start_d;
  logic [15:0]      fb_addr_p0_q, fb_addr_p0_d;
  logic             fb_re_p0_q, fb_re_p0_d;
  logic             win_p0_q, win_p0_d;
  logic [11:0]      rgb_p1_q, rgb_p1_d;
  logic             hs_p1_q, hs_p1_d;
  logic             vs_p1_q, vs_p1_d;
  logic             blank_p1_q, blank_p1_d;

  logic       tick, adv, stage_b, win;
  logic [9:0] h_off, v_off;

  // Pixel divider and screen position counters.
  always_comb begin
    tick    = (div_cnt_q == '0);
    adv     = (div_cnt_q == DIV_LAST);
    stage_b = (div_cnt_q == DIV_B);
    div_cnt_d = adv ? '0 : div_cnt_q + DIV_W'(1);
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (adv) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
    frame_start_d = adv && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
  end

  // Stage A: window test and buffer read request on the pixel tick.
  always_comb begin
    win   = (h_cnt_q >= WX0) && (h_cnt_q < WX1) && (v_cnt_q >= WY0) && (v_cnt_q < WY1);
    h_off = h_cnt_q - WX0;
    v_off = v_cnt_q - WY0;
    fb_re_p0_d   = tick && win;
    fb_addr_p0_d = (tick && win) ? pack_addr(h_off, v_off) : fb_addr_p0_q;
    win_p0_d     = tick ? win : win_p0_q;
  end

  // Stage B: capture colour (or black) with sync and blank from the same h/v.
  always_comb begin
    rgb_p1_d   = rgb_p1_q;
    hs_p1_d    = hs_p1_q;
    vs_p1_d    = vs_p1_q;
    blank_p1_d = blank_p1_q;
    if (stage_b) begin
      rgb_p1_d   = win_p0_q ? bus.fb_rdata : 12'h000;
      hs_p1_d    = ~((h_cnt_q >= HS0) && (h_cnt_q < HS1));
      vs_p1_d    = ~((v_cnt_q >= VS0) && (v_cnt_q < VS1));
      blank_p1_d = (v_cnt_q >= VVIS);
    end
  end

  // All state clears immediately on reset; a pixel in flight is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_start_q <= 1'b0;
      fb_addr_p0_q  <= '0;
      fb_re_p0_q    <= 1'b0;
      win_p0_q      <= 1'b0;
      rgb_p1_q      <= '0;
      hs_p1_q       <= 1'b1;
      vs_p1_q       <= 1'b1;
      blank_p1_q    <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
      fb_addr_p0_q  <= fb_addr_p0_d;
      fb_re_p0_q    <= fb_re_p0_d;
      win_p0_q      <= win_p0_d;
      rgb_p1_q      <= rgb_p1_d;
      hs_p1_q       <= hs_p1_d;
      vs_p1_q       <= vs_p1_d;
      blank_p1_q    <= blank_p1_d;
    end
  end

  assign bus.fb_addr     = fb_addr_p0_q;
  assign bus.fb_re       = fb_re_p0_q;
  assign bus.vga_r       = rgb_p1_q[11:8];
  assign bus.vga_g       = rgb_p1_q[7:4];
  assign bus.vga_b       = rgb_p1_q[3:0];
  assign bus.vga_hs      = hs_p1_q;
  assign bus.vga_vs      = vs_p1_q;
  assign bus.in_vblank   = blank_p1_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader on a shrunken screen (same rules, small frame)
// against a reference model computed from the clock count since reset.
module tb_vga_frame_reader;
  localparam int CD  = 4;
  localparam int HV  = 24, HF = 2, HSW = 3, HB = 3;
  localparam int VV  = 16, VF = 1, VSW = 2, VB = 2;
  localparam int WX0 = 4, WY0 = 2, SW = 8, SH = 6;
  localparam int HT  = HV + HF + HSW + HB;
  localparam int VT  = VV + VF + VSW + VB;
  localparam int FRAME_CLK = HT * VT * CD;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_frame_reader_if bus();

  vga_frame_reader #(
    .CLK_DIV(CD), .H_VIS(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .WIN_X0(WX0), .WIN_Y0(WY0), .SRC_W(SW), .SRC_H(SH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] mem [0:65535];

  logic [15:0] m_addr;
  logic        m_win, m_re, m_hs, m_vs, m_blank, m_fs;
  logic [11:0] m_rgb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit in_win(input int h, input int v);
    return (h >= WX0) && (h < WX0 + 2 * SW) && (v >= WY0) && (v < WY0 + 2 * SH);
  endfunction

  function automatic logic [15:0] addr_of(input int h, input int v);
    return 16'(((v - WY0) / 2) * 256 + (h - WX0) / 2);
  endfunction

  task automatic model_reset();
    m_addr = '0; m_win = 1'b0; m_re = 1'b0; m_rgb = '0;
    m_hs = 1'b1; m_vs = 1'b1; m_blank = 1'b0; m_fs = 1'b0;
  endtask

  // Expected outputs after posedge number ed (0 = first edge after release).
  task automatic model_edge(input int ed);
    int p, ph, h, v;
    p  = ed / CD;
    ph = ed % CD;
    h  = p % HT;
    v  = (p / HT) % VT;
    m_re = 1'b0;
    if (ph == 0) begin
      m_win = in_win(h, v);
      m_re  = m_win;
      if (m_win) m_addr = addr_of(h, v);
    end
    if (ph == 1) begin
      m_rgb   = m_win ? mem[m_addr] : 12'h000;
      m_hs    = !((h >= HV + HF) && (h < HV + HF + HSW));
      m_vs    = !((v >= VV + VF) && (v < VV + VF + VSW));
      m_blank = (v >= VV);
    end
    m_fs = (ph == CD - 1) && (h == HT - 1) && (v == VT - 1);
  endtask

  task automatic check_outputs();
    check("fb_re", 32'(bus.fb_re), 32'(m_re));
    check("fb_addr", 32'(bus.fb_addr), 32'(m_addr));
    check("rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(m_rgb));
    check("vga_hs", 32'(bus.vga_hs), 32'(m_hs));
    check("vga_vs", 32'(bus.vga_vs), 32'(m_vs));
    check("in_vblank", 32'(bus.in_vblank), 32'(m_blank));
    check("frame_start", 32'(bus.frame_start), 32'(m_fs));
  endtask

  // Runs a bit over two frames from reset release, checking every cycle.
  task automatic run_after_release();
    int first_re = -1;
    int re_cnt = 0, hs_low = 0, vs_low = 0;
    int fs_prev = -1, fs_period = -1;
    logic [15:0] max_addr = '0;
    model_reset();
    for (int ed = 0; ed < 2 * FRAME_CLK + 100; ed++) begin
      @(posedge clk);
      model_edge(ed);
      @(negedge clk);
      check_outputs();
      if (bus.fb_re) begin
        if (first_re < 0) first_re = ed;
        if (ed < FRAME_CLK) re_cnt++;
        if (bus.fb_addr > max_addr) max_addr = bus.fb_addr;
      end
      if (ed >= FRAME_CLK && ed < 2 * FRAME_CLK) begin
        if (!bus.vga_hs) hs_low++;
        if (!bus.vga_vs) vs_low++;
      end
      if (bus.frame_start) begin
        if (fs_prev >= 0) fs_period = ed - fs_prev;
        fs_prev = ed;
      end
      // Memory answers a read one clk later; otherwise drive junk.
      bus.fb_rdata = bus.fb_re ? mem[bus.fb_addr] : 12'($urandom);
    end
    check("first_re_clk", 32'(first_re), 32'((WY0 * HT + WX0) * CD));
    check("reads_per_frame", 32'(re_cnt), 32'(SW * SH * 4));
    check("max_addr", 32'(max_addr), 32'(((SH - 1) << 8) | (SW - 1)));
    check("hs_low_clk", 32'(hs_low), 32'(HSW * CD * VT));
    check("vs_low_clk", 32'(vs_low), 32'(VSW * HT * CD));
    check("frame_period", 32'(fs_period), 32'(FRAME_CLK));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 12'($urandom);
    bus.fb_rdata = 12'h000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    check_outputs();
    rst = 1'b0;
    run_after_release();

    // Mid-line reset between clock edges: outputs must clear at once.
    repeat ($urandom_range(CD * HT * (WY0 + 1), CD * HT * (WY0 + 3))) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_after_release();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
